gpr_wb_scheduler: RTL

GPR_WB_SCHEDULER -- requirements
Module: gpr_wb_scheduler

---
 rtl/gpr_pkg.sv | 10 +
 rtl/gpr_wb_scheduler_rr_arb2.sv | 31 +++
 rtl/gpr_wb_scheduler.sv | 100 ++++++++++
 3 files changed

// File: rtl/gpr_pkg.sv
// Shared constants and types for the GPR writeback scheduler slice.
package gpr_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_MEM = 1'b1
    } wb_src_t;
endpackage

// File: rtl/gpr_wb_scheduler_rr_arb2.sv
// Two-way round-robin arbiter: req/gnt bit 0 is the ALU, bit 1 the load unit.
module rr_arb2
    import gpr_pkg::*;
(
    input  logic       clk,
    input  logic       rstn,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    wb_src_t last_gnt;

    // On contention the source that did not win most recently goes first.
    always_comb begin
        gnt = 2'b00;
        if (req[0] && (!req[1] || last_gnt == SRC_MEM))
            gnt[0] = 1'b1;
        else if (req[1])
            gnt[1] = 1'b1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            last_gnt <= SRC_MEM;
        else if (gnt[1])
            last_gnt <= SRC_MEM;
        else if (gnt[0])
            last_gnt <= SRC_ALU;
    end

endmodule

// File: rtl/gpr_wb_scheduler.sv
// Register scoreboard plus single-port writeback scheduler for the ALU and load unit.
module gpr_wb_scheduler
    import gpr_pkg::*;
#(
    parameter int WordSize = 32
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  iss_valid,
    input  logic [REG_ADDR_W-1:0] iss_rd,
    input  logic [REG_ADDR_W-1:0] iss_rs1,
    input  logic [REG_ADDR_W-1:0] iss_rs2,
    output logic                  iss_stall,
    input  logic                  alu_valid,
    input  logic [REG_ADDR_W-1:0] alu_rd,
    input  logic [WordSize-1:0]   alu_data,
    output logic                  alu_ready,
    input  logic                  mem_valid,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic [WordSize-1:0]   mem_data,
    output logic                  mem_ready,
    output logic                  wbe,
    output logic [REG_ADDR_W-1:0] rdn,
    output logic [WordSize-1:0]   rdd,
    output logic [NUM_REGS-1:0]   busy,
    output logic                  err
);

    logic [NUM_REGS-1:0]   busy_q;
    logic [NUM_REGS-1:0]   busy_nxt;
    logic [1:0]            gnt;
    logic                  iss_acc;
    logic                  wb_acc;
    logic [REG_ADDR_W-1:0] wb_rd;
    logic [WordSize-1:0]   wb_data;
    logic                  wbe_p1;
    logic [REG_ADDR_W-1:0] rdn_p1;
    logic [WordSize-1:0]   rdd_p1;
    logic                  err_q;

    rr_arb2 u_arb (
        .clk  (clk),
        .rstn (rstn),
        .req  ({mem_valid, alu_valid}),
        .gnt  (gnt)
    );

    assign alu_ready = gnt[0];
    assign mem_ready = gnt[1];
    assign wb_acc    = gnt[0] | gnt[1];
    assign wb_rd     = gnt[1] ? mem_rd   : alu_rd;
    assign wb_data   = gnt[1] ? mem_data : alu_data;

    // busy_q[0] is never set, so register 0 cannot cause a hazard.
    assign iss_stall = iss_valid & (busy_q[iss_rs1] | busy_q[iss_rs2] | busy_q[iss_rd]);
    assign iss_acc   = iss_valid & ~iss_stall;

    // Clear on writeback first, then set on issue, so a same-edge set wins.
    always_comb begin
        busy_nxt = busy_q;
        if (wb_acc)
            busy_nxt[wb_rd] = 1'b0;
        if (iss_acc && iss_rd != '0)
            busy_nxt[iss_rd] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            busy_q <= '0;
            err_q  <= 1'b0;
        end else begin
            busy_q <= busy_nxt;
            if (wb_acc && wb_rd != '0 && !busy_q[wb_rd])
                err_q <= 1'b1;
        end
    end

    // p1: registered register-file write port, address/data hold when idle
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wbe_p1 <= 1'b0;
            rdn_p1 <= '0;
            rdd_p1 <= '0;
        end else begin
            wbe_p1 <= wb_acc && wb_rd != '0;
            if (wb_acc && wb_rd != '0) begin
                rdn_p1 <= wb_rd;
                rdd_p1 <= wb_data;
            end
        end
    end

    assign wbe  = wbe_p1;
    assign rdn  = rdn_p1;
    assign rdd  = rdd_p1;
    assign busy = busy_q;
    assign err  = err_q;

endmodule
